flex_down_timer: RTL and testbench
==================================

Name: flex_down_timer

Overview:
- Parameterized, programmable down-counting timer; the load-and-expire counterpart of the team's up-counting flex counter.
- Loads a start value, decrements on enabled cycles and signals expiry.
- Operates in one-shot or periodic (auto-reload) mode.
- Used by protocol blocks that need "wait N bit-times / N enabled ticks" timeouts instead of "count up to rollover".

Parameters:
NUM_CNT_BITS, 4, width of load value, reload register and count_out.

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear; returns block to IDLE
count_enable  input  1  decrement qualifier; low = hold/pause
start  input  1  single-cycle request to load load_val and run
periodic  input  1  mode sampled at start: 1 = auto-reload, 0 = one-shot
load_val  input  NUM_CNT_BITS  start/reload value, sampled at start
count_out  output  NUM_CNT_BITS  current remaining count (registered)
terminal_flag  output  1  registered; high while in RUN with count_out == 1
expire  output  1  registered one-cycle pulse on each expiry
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot expired, awaiting start/clear)

Behaviour:
- Reset (n_rst low, async):
  - state = IDLE; count_out, reload register and mode register = 0.
  - terminal_flag, expire, busy, done = 0.
- Priority per edge: n_rst > clear > start > count_enable.
- clear: next edge state = IDLE; count_out = 0; all flags = 0. clear and start together: clear wins.
- start, valid only if load_val != 0 (load_val == 0 is ignored in every state; state and outputs are unchanged):
  - Valid in any state, including RUN (restart).
  - Next edge: count_out = load_val; reload register = load_val; mode register = periodic; state = RUN; expire = 0.
  - No decrement on the start cycle, even if count_enable is high.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> RUN on decrement or periodic reload.
  - RUN -> DONE on one-shot expiry.
  - DONE -> RUN on start.
  - Any -> IDLE on clear.
- RUN with count_enable high:
  - count_out > 1: count_out decrements by 1.
  - count_out == 1 is an expiry:
    - Periodic: count_out = reload register, state stays RUN.
    - One-shot: count_out = 0, state = DONE.
    - Either mode: expire = 1 for exactly the following cycle.
- RUN with count_enable low: count_out and state hold; expire = 0.
- terminal_flag is computed from the next-state value: high in the cycle(s) where state == RUN and count_out == 1. This includes load_val == 1 immediately after start.
- Expiry and start in the same cycle: start wins, no expire pulse.
- busy = (state == RUN); done = (state == DONE), both registered.
- Periodic with load_val == 1: expire pulses on every enabled cycle; terminal_flag stays high.
- No wrap below 0; count_out never underflows.
- Reset asserted mid-count: immediate return to reset values. Deassertion alone does not restart the timer.

Test Plan:
- Reset: n_rst low for 2 cycles mid-RUN (count_out = 5) -> count_out = 0, busy = 0, done = 0, expire = 0 immediately and after release.
- One-shot: start with load_val = 3, periodic = 0, count_enable held high -> count_out sequence 3, 2, 1, 0; terminal_flag high only while count_out = 1; expire high for one cycle together with done = 1; count_out remains 0 afterwards.
- Periodic: start with load_val = 4, periodic = 1, enable high for 10 edges after load -> count_out 4, 3, 2, 1, 4, 3, 2, 1, 4, 3, 2; expire pulses twice, each one cycle, after the 1 -> 4 reload; busy stays 1.
- Pause: load_val = 5, enable toggles 1, 0, 0, 1 -> count_out 5, 4, 4, 4, 3; no spurious flags.
- Clear/restart: clear during RUN at count 2 -> IDLE, count_out = 0. Restart with start at count_out = 1 and load_val = 6 in the same cycle as an enabled expiry -> count_out = 6, no expire pulse. start with load_val = 0 -> ignored, state unchanged.
- Max value: NUM_CNT_BITS = 4, load_val = 15, one-shot, enable high -> exactly 15 enabled edges until expire; count_out never exceeds 15 or underflows.

Source files
------------

// File: rtl/flex_down_timer.sv
// Purpose : programmable down-counting timer with one-shot and periodic (auto-reload) modes.
// Latency : all outputs registered; count_out reflects load_val one edge after start.
// Backpres: none; count_enable low pauses the count, start restarts from any state.
//
// Ports:
//   clk, n_rst            - clock (rising edge) and asynchronous active-low reset
//   clear                 - synchronous return to IDLE, highest priority after reset
//   count_enable          - decrement qualifier
//   start, periodic,      - load request; mode and load value are sampled with start,
//   load_val                a zero load value is treated as no request
//   count_out             - remaining count
//   terminal_flag         - RUN with count_out == 1
//   expire                - one-cycle pulse per expiry
//   busy / done           - state == RUN / state == DONE
module flex_down_timer #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    start,
  input  logic                    periodic,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    terminal_flag,
  output logic                    expire,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    mode_q, mode_d;
  logic                    expire_q, expire_d;
  logic                    term_q, busy_q, done_q;
  logic                    start_ok;

  // A zero load value would expire without ever counting, so it is not a request.
  assign start_ok = start && (load_val != CNT_ZERO);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = CNT_ZERO;
    end else if (start_ok) begin
      // Loading takes the whole cycle; no decrement even with count_enable high,
      // and a coincident expiry is swallowed by the restart.
      state_d  = RUN;
      count_d  = load_val;
      reload_d = load_val;
      mode_d   = periodic;
    end else if ((state_q == RUN) && count_enable) begin
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else begin
        expire_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = CNT_ZERO;
          state_d = DONE;
        end
      end
    end
  end

  // Flags are derived from next-state values so they line up with count_out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      term_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      term_q   <= (state_d == RUN) && (count_d == CNT_ONE);
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign count_out     = count_q;
  assign terminal_flag = term_q;
  assign expire        = expire_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_flex_down_timer.sv
module tb_flex_down_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear, count_enable, start, periodic;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       terminal_flag, expire, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flex_down_timer #(.NUM_CNT_BITS(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .start        (start),
    .periodic     (periodic),
    .load_val     (load_val),
    .count_out    (count_out),
    .terminal_flag(terminal_flag),
    .expire       (expire),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic       clr, en, st, per;
    logic [3:0] ld;
    logic [3:0] cnt;
    logic       tf, ex, bsy, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic clr, logic en, logic st, logic per, logic [3:0] ld,
                              logic [3:0] cnt, logic tf, logic ex, logic bsy, logic dn);
    vec_t v;
    v.clr = clr; v.en = en; v.st = st; v.per = per; v.ld = ld;
    v.cnt = cnt; v.tf = tf; v.ex = ex; v.bsy = bsy; v.dn = dn;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] cnt, logic tf, logic ex, logic bsy, logic dn);
    vectors++;
    if (count_out !== cnt || terminal_flag !== tf || expire !== ex || busy !== bsy || done !== dn) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d tf=%b ex=%b busy=%b done=%b, want cnt=%0d tf=%b ex=%b busy=%b done=%b",
               name, count_out, terminal_flag, expire, busy, done, cnt, tf, ex, bsy, dn);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(logic clr, logic en, logic st, logic per, logic [3:0] ld);
    clear = clr; count_enable = en; start = st; periodic = per; load_val = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   clr en st per ld     cnt tf ex bsy dn
    // one-shot, load 3
    add(0, 1, 1, 0, 4'd3,  4'd3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0, 1);
    // periodic, load 4, 10 enabled edges after the load
    add(0, 1, 1, 1, 4'd4,  4'd4, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd4, 0, 1, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd4, 0, 1, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd2, 0, 0, 1, 0);
    // restart from RUN into one-shot load 5, then pause pattern 1,0,0,1
    add(0, 0, 1, 0, 4'd5,  4'd5, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd4, 0, 0, 1, 0);
    add(0, 0, 0, 0, 4'd0,  4'd4, 0, 0, 1, 0);
    add(0, 0, 0, 0, 4'd0,  4'd4, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd2, 0, 0, 1, 0);
    // clear at count 2
    add(1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0, 0);
    // start with zero load from IDLE is ignored
    add(0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0);
    // restart on the same edge as an enabled expiry
    add(0, 1, 1, 0, 4'd2,  4'd2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 0, 1, 0);
    add(0, 1, 1, 0, 4'd6,  4'd6, 0, 0, 1, 0);
    // start with zero load in RUN is ignored
    add(0, 0, 1, 1, 4'd0,  4'd6, 0, 0, 1, 0);
    // clear and start together: clear wins
    add(1, 1, 1, 0, 4'd7,  4'd0, 0, 0, 0, 0);
    // periodic load 1: terminal_flag stays high, expire every enabled edge
    add(0, 1, 1, 1, 4'd1,  4'd1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 1, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 4'd0,  4'd1, 1, 0, 1, 0);
    // one-shot load 1, then restart out of DONE
    add(0, 1, 1, 0, 4'd1,  4'd1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 4'd0,  4'd0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 4'd3,  4'd3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0, 0);

    clear = 0; count_enable = 0; start = 0; periodic = 0; load_val = 4'd0;
    n_rst = 1'b0;
    #12;
    check("reset_state", 4'd0, 0, 0, 0, 0);
    n_rst = 1'b1;
    step(0, 1, 0, 0, 4'd0);
    check("idle_after_reset", 4'd0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].en, tbl[i].st, tbl[i].per, tbl[i].ld);
      check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].tf, tbl[i].ex, tbl[i].bsy, tbl[i].dn);
    end

    // Reset asserted mid-RUN at count 5, held for 2 cycles.
    step(0, 0, 1, 1, 4'd5);
    check("pre_reset_run", 4'd5, 0, 0, 1, 0);
    n_rst = 1'b0;
    #1;
    check("reset_async", 4'd0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 4'd0);
    step(0, 1, 0, 0, 4'd0);
    check("reset_held", 4'd0, 0, 0, 0, 0);
    n_rst = 1'b1;
    step(0, 1, 0, 0, 4'd0);
    check("reset_release", 4'd0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 4'd0);
    check("reset_no_restart", 4'd0, 0, 0, 0, 0);

    // Maximum load: expiry after exactly 15 enabled edges.
    step(0, 1, 1, 0, 4'd15);
    check("max_load", 4'd15, 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 1, 0, 0, 4'd0);
      check($sformatf("max_edge%0d", k), 4'(15 - k), (k == 14), (k == 15), (k < 15), (k == 15));
    end
    step(0, 1, 0, 0, 4'd0);
    check("max_after", 4'd0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
